// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage RISC-V pipeline.
//   Resolves load-use hazards, taken-branch flushes, data-memory wait states
//   and multi-cycle EX operations, drives the pipeline register enables and
//   bubble inserts, and keeps saturating stall/flush performance counters.
//   Control outputs are combinational from the registered state and the
//   current-cycle hazard inputs so that a hazard takes effect in the cycle
//   it is detected.
module pipeline_hazard_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_is_mc,
  input  logic             mc_done,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mc_start,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Watchdog timer only needs to hold 0 .. MC_TIMEOUT-1.
  localparam int            TW    = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam bit            WD_EN = (MC_TIMEOUT > 0);
  localparam logic [TW-1:0] TMAX  = TW'((MC_TIMEOUT > 0) ? (MC_TIMEOUT - 1) : 0);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          done_pend;
  logic          done_pend_nxt;
  logic [TW-1:0] mc_timer;
  logic [TW-1:0] mc_timer_nxt;
  logic          load_use;
  logic          set_timeout;
  logic          branch_flush;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Priority resolution of hazards into enables, bubbles and next state.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    mc_start      = 1'b0;
    state_nxt     = state;
    done_pend_nxt = done_pend;
    mc_timer_nxt  = mc_timer;
    set_timeout   = 1'b0;
    branch_flush  = 1'b0;

    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
      mem_wb_flush  = 1'b1;
      state_nxt     = RUN;
      done_pend_nxt = 1'b0;
      mc_timer_nxt  = '0;
    end else if (dmem_busy) begin
      // Whole front of the pipe freezes; MEM/WB gets a bubble.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
      if (state == MC_BUSY) begin
        // Remember a completion that arrives while MEM is stalled.
        if (mc_done) begin
          done_pend_nxt = 1'b1;
        end else begin
          done_pend_nxt = done_pend;
        end
        // Timer holds at its limit so the watchdog fires once MEM frees up.
        if (mc_timer != TMAX) begin
          mc_timer_nxt = mc_timer + {{(TW-1){1'b0}}, 1'b1};
        end else begin
          mc_timer_nxt = mc_timer;
        end
      end else begin
        done_pend_nxt = done_pend;
      end
    end else if (state == MC_BUSY) begin
      if (mc_done || done_pend) begin
        // Result valid: EX/MEM captures it with default enables.
        state_nxt     = RUN;
        done_pend_nxt = 1'b0;
      end else if (WD_EN && (mc_timer == TMAX)) begin
        // Watchdog: abandon the op, release the pipe like a normal completion.
        set_timeout   = 1'b1;
        state_nxt     = RUN;
        done_pend_nxt = 1'b0;
      end else begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
        mc_timer_nxt = mc_timer + {{(TW-1){1'b0}}, 1'b1};
      end
    end else if (ex_branch_taken) begin
      // Wrong-path instructions in IF/ID and ID/EX are squashed.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      branch_flush = 1'b1;
    end else if (ex_is_mc) begin
      mc_start     = 1'b1;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_flush = 1'b1;
      state_nxt    = MC_BUSY;
      mc_timer_nxt = '0;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else begin
      state_nxt = RUN;
    end
  end

  // Sequencer state, watchdog flag and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      done_pend  <= 1'b0;
      mc_timer   <= '0;
      mc_timeout <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      done_pend <= done_pend_nxt;
      mc_timer  <= mc_timer_nxt;
      if (set_timeout) begin
        mc_timeout <= 1'b1;
      end
      if (!pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (branch_flush && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (watchdog shortened to 8).
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic        ex_is_mc, mc_done, dmem_busy;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic        mc_start, mc_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Control vector order:
  // {pc,if_id,id_ex,ex_mem _write, if_id,id_ex,ex_mem,mem_wb _flush, mc_start}
  localparam logic [8:0] V_DEF = 9'b1111_0000_0;
  localparam logic [8:0] V_RST = 9'b0000_1111_0;
  localparam logic [8:0] V_LU  = 9'b0011_0100_0;
  localparam logic [8:0] V_BR  = 9'b1111_1100_0;
  localparam logic [8:0] V_MCS = 9'b0001_0010_1;
  localparam logic [8:0] V_MCB = 9'b0001_0010_0;
  localparam logic [8:0] V_DMB = 9'b0000_0001_0;

  logic [8:0] ctl;
  assign ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mc_start};

  pipeline_hazard_ctrl #(.CNT_W(32), .MC_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_is_mc(ex_is_mc),
    .mc_done(mc_done), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .mc_start(mc_start), .mc_timeout(mc_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with inputs applied: checks controls, advances one cycle.
  task automatic cyc(input string tag, input logic [8:0] exp);
    #1;
    chk(tag, {23'd0, ctl}, {23'd0, exp});
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_is_mc = 1'b0; mc_done = 1'b0; dmem_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    cyc("rst_ctl", V_RST);
    rst = 1'b0;
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    chk("rst_timeout", {31'd0, mc_timeout}, 32'd0);
    cyc("idle", V_DEF);

    // Load-use via rs2
    ex_rd = 5'd5; ex_mem_read = 1'b1;
    id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    cyc("lu_rs2", V_LU);
    idle_inputs();
    chk("lu_stall_cnt1", stall_cnt, 32'd1);
    cyc("lu_after", V_DEF);

    // Load-use via rs1
    ex_rd = 5'd7; ex_mem_read = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    cyc("lu_rs1", V_LU);
    // No hazard: rd = x0
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    cyc("lu_x0", V_DEF);
    // No hazard: operand not used
    ex_rd = 5'd5; id_rs1 = 5'd1; id_rs2 = 5'd5; id_use_rs2 = 1'b0;
    cyc("lu_unused", V_DEF);
    // No hazard: not a load
    ex_mem_read = 1'b0; id_use_rs2 = 1'b1;
    cyc("lu_noload", V_DEF);
    chk("lu_stall_cnt2", stall_cnt, 32'd2);

    // Taken branch overrides load-use
    ex_mem_read = 1'b1; ex_branch_taken = 1'b1;
    cyc("branch_lu", V_BR);
    idle_inputs();
    chk("branch_flush_cnt", flush_cnt, 32'd1);
    chk("branch_stall_cnt", stall_cnt, 32'd2);

    // dmem_busy dominates, including over a taken branch
    dmem_busy = 1'b1;
    cyc("dmem_run", V_DMB);
    ex_branch_taken = 1'b1;
    cyc("dmem_branch", V_DMB);
    idle_inputs();
    chk("dmem_flush_cnt", flush_cnt, 32'd1);
    chk("dmem_stall_cnt", stall_cnt, 32'd4);

    // Multi-cycle op, done 4 cycles after start
    ex_is_mc = 1'b1;
    cyc("mc_start", V_MCS);
    for (int i = 0; i < 3; i++) cyc("mc_busy", V_MCB);
    mc_done = 1'b1;
    cyc("mc_exit", V_DEF);
    idle_inputs();
    chk("mc_stall_cnt", stall_cnt, 32'd8);
    // mc_done in RUN ignored
    mc_done = 1'b1;
    cyc("done_in_run", V_DEF);
    mc_done = 1'b0;

    // Completion during dmem_busy is held until MEM frees up
    ex_is_mc = 1'b1;
    cyc("pend_start", V_MCS);
    cyc("pend_busy", V_MCB);
    dmem_busy = 1'b1; mc_done = 1'b1;
    cyc("pend_dmem_done", V_DMB);
    mc_done = 1'b0;
    cyc("pend_dmem1", V_DMB);
    cyc("pend_dmem2", V_DMB);
    dmem_busy = 1'b0;
    cyc("pend_exit", V_DEF);
    ex_is_mc = 1'b0;
    cyc("pend_run", V_DEF);
    chk("pend_stall_cnt", stall_cnt, 32'd13);
    chk("pend_no_timeout", {31'd0, mc_timeout}, 32'd0);

    // Watchdog: no mc_done, fires on 8th MC_BUSY cycle
    ex_is_mc = 1'b1;
    cyc("wd_start", V_MCS);
    for (int i = 0; i < 7; i++) cyc("wd_busy", V_MCB);
    chk("wd_not_yet", {31'd0, mc_timeout}, 32'd0);
    cyc("wd_fire", V_DEF);
    chk("wd_flag", {31'd0, mc_timeout}, 32'd1);
    ex_is_mc = 1'b0;
    cyc("wd_run", V_DEF);
    chk("wd_sticky", {31'd0, mc_timeout}, 32'd1);
    chk("wd_stall_cnt", stall_cnt, 32'd21);

    // Reset in the middle of MC_BUSY
    ex_is_mc = 1'b1;
    cyc("rmc_start", V_MCS);
    cyc("rmc_busy", V_MCB);
    rst = 1'b1;
    cyc("rmc_rst", V_RST);
    rst = 1'b0; ex_is_mc = 1'b0;
    chk("rmc_timeout", {31'd0, mc_timeout}, 32'd0);
    chk("rmc_stall_cnt", stall_cnt, 32'd0);
    chk("rmc_flush_cnt", flush_cnt, 32'd0);
    cyc("rmc_run", V_DEF);
    ex_rd = 5'd9; ex_mem_read = 1'b1; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    cyc("rmc_lu", V_LU);
    idle_inputs();
    chk("rmc_stall_after", stall_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
